// File: rtl/wbu_pkg.sv
// wbu_pkg
// Shared constants and types for the receive side of the debug-bus serial
// link. It holds the codeword width, the sextet codes for the two
// punctuation characters, the codeword length table, and the assembly state
// encoding.
//
// Contents:
//   CODEWORD_W            width of an assembled bus codeword (36)
//   SEXTET_AT, SEXTET_PCT sextet codes for '@' and '%'
//   LEN_FULL/LEN_3/LEN_2/LEN_1  codeword lengths in sextets
//   asm_state_t           IDLE / ASSEMBLE states of the word assembler
//   word_length()         maps the first sextet's top two bits to a length
package wbu_pkg;

  localparam int unsigned CODEWORD_W = 36;

  localparam logic [5:0] SEXTET_AT  = 6'd62;
  localparam logic [5:0] SEXTET_PCT = 6'd63;

  localparam logic [2:0] LEN_FULL = 3'd6;
  localparam logic [2:0] LEN_3    = 3'd3;
  localparam logic [2:0] LEN_2    = 3'd2;
  localparam logic [2:0] LEN_1    = 3'd1;

  typedef enum logic {
    ST_IDLE,
    ST_ASSEMBLE
  } asm_state_t;

  // The two most significant bits of the leading sextet encode how many
  // sextets make up the whole word, including the leading one.
  function automatic logic [2:0] word_length(input logic [1:0] tag);
    logic [2:0] len;
    case (tag)
      2'b00:   len = LEN_FULL;
      2'b01:   len = LEN_3;
      2'b10:   len = LEN_2;
      default: len = LEN_1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/wbu_char_decode.sv
// wbu_char_decode
// One-stage registered decoder that turns a printable byte from the UART
// receiver into a 6-bit sextet. Bytes outside the alphabet are reported as
// invalid. The assembler treats them as word separators.
//
// Alphabet: '0'-'9' -> 0-9, 'A'-'Z' -> 10-35, 'a'-'z' -> 36-61,
//           '@' -> 62, '%' -> 63.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   byte_stb      byte valid (single-cycle pulse)
//   byte_data     received byte
//   sextet_stb    registered strobe, one cycle after byte_stb
//   sextet_valid  registered flag: byte was part of the alphabet
//   sextet        registered 6-bit decoded value
module wbu_char_decode
  import wbu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_stb,
  input  logic [7:0] byte_data,
  output logic       sextet_stb,
  output logic       sextet_valid,
  output logic [5:0] sextet
);

  logic       dec_valid;
  logic [5:0] dec_value;
  logic [7:0] offset_value;

  // Each alphabet range is a contiguous block of ASCII codes. Subtracting a
  // per-range offset gives the sextet directly, and the low six bits of the
  // difference carry the result.
  always_comb begin
    dec_valid    = 1'b0;
    dec_value    = 6'd0;
    offset_value = 8'd0;
    if (byte_data >= 8'h30 && byte_data <= 8'h39) begin
      dec_valid    = 1'b1;
      offset_value = byte_data - 8'h30;
      dec_value    = offset_value[5:0];
    end else if (byte_data >= 8'h41 && byte_data <= 8'h5A) begin
      dec_valid    = 1'b1;
      offset_value = byte_data - 8'd55;
      dec_value    = offset_value[5:0];
    end else if (byte_data >= 8'h61 && byte_data <= 8'h7A) begin
      dec_valid    = 1'b1;
      offset_value = byte_data - 8'd61;
      dec_value    = offset_value[5:0];
    end else if (byte_data == 8'h40) begin
      dec_valid = 1'b1;
      dec_value = SEXTET_AT;
    end else if (byte_data == 8'h25) begin
      dec_valid = 1'b1;
      dec_value = SEXTET_PCT;
    end
  end

  // The valid flag only qualifies a strobed cycle. The value register holds
  // its last content when no byte arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sextet_stb   <= 1'b0;
      sextet_valid <= 1'b0;
      sextet       <= 6'd0;
    end else begin
      sextet_stb   <= byte_stb;
      sextet_valid <= byte_stb & dec_valid;
      if (byte_stb) begin
        sextet <= dec_value;
      end
    end
  end

endmodule

// File: rtl/wbu_input_assemble.sv
// wbu_input_assemble
// Receive-side word assembler for the debug-bus serial link. Printable bytes
// are decoded to sextets by wbu_char_decode. The sextets are then packed
// MSB-first into 36-bit codewords. The first sextet of a word sets the word
// length. Any non-alphabet byte aborts a partial word. A completed word is
// presented on o_stb/o_codword and held until the downstream side is not busy.
//
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   i_stb       byte valid from the UART receiver
//   i_byte      received byte
//   o_stb       codeword valid, held until a cycle with !i_busy
//   o_codword   assembled codeword, left-aligned, unused low bits zero
//   i_busy      downstream busy; a transfer happens on o_stb && !i_busy
//   o_active    a partial word is in progress
//   o_overflow  one-cycle pulse when a completed word had to be dropped
module wbu_input_assemble
  import wbu_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stb,
  input  logic [7:0]            i_byte,
  output logic                  o_stb,
  output logic [CODEWORD_W-1:0] o_codword,
  input  logic                  i_busy,
  output logic                  o_active,
  output logic                  o_overflow
);

  logic       d_stb;
  logic       d_valid;
  logic [5:0] d_sextet;

  asm_state_t            state, next_state;
  logic [2:0]            count, next_count;
  logic [2:0]            pos, next_pos;
  logic [CODEWORD_W-1:0] word, next_word;

  logic                  complete;
  logic [CODEWORD_W-1:0] complete_word;
  logic [2:0]            len;
  logic [5:0]            shamt;
  logic [CODEWORD_W-1:0] merged;

  wbu_char_decode u_decode (
    .clk          (i_clk),
    .rst          (i_rst),
    .byte_stb     (i_stb),
    .byte_data    (i_byte),
    .sextet_stb   (d_stb),
    .sextet_valid (d_valid),
    .sextet       (d_sextet)
  );

  // Assembly state register. The state mirrors whether count is non-zero,
  // and both are kept so the branch structure below reads as an FSM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      count <= 3'd0;
      pos   <= 3'd0;
      word  <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
      pos   <= next_pos;
      word  <= next_word;
    end
  end

  // Next-state logic for the assembler. A completed word leaves through
  // complete/complete_word. The internal word register clears so the next
  // word starts clean. A separator drops any partial progress.
  always_comb begin
    next_state    = state;
    next_count    = count;
    next_pos      = pos;
    next_word     = word;
    complete      = 1'b0;
    complete_word = '0;
    len           = word_length(d_sextet[5:4]);
    shamt         = 6'(pos) * 6'd6;
    merged        = word | ({d_sextet, 30'b0} >> shamt);

    if (d_stb) begin
      if (!d_valid) begin
        next_count = 3'd0;
        next_pos   = 3'd0;
        next_word  = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (len == LEN_1) begin
              complete      = 1'b1;
              complete_word = {d_sextet, 30'b0};
              next_count    = 3'd0;
              next_pos      = 3'd0;
              next_word     = '0;
            end else begin
              next_word  = {d_sextet, 30'b0};
              next_pos   = 3'd1;
              next_count = len - 3'd1;
            end
          end
          ST_ASSEMBLE: begin
            if (count == 3'd1) begin
              complete      = 1'b1;
              complete_word = merged;
              next_count    = 3'd0;
              next_pos      = 3'd0;
              next_word     = '0;
            end else begin
              next_word  = merged;
              next_pos   = pos + 3'd1;
              next_count = count - 3'd1;
            end
          end
          default: begin
            next_count = 3'd0;
            next_pos   = 3'd0;
            next_word  = '0;
          end
        endcase
      end
    end

    next_state = (next_count != 3'd0) ? ST_ASSEMBLE : ST_IDLE;
  end

  assign o_active = (count != 3'd0);

  // Output holding register. A new word may replace the held one in the
  // same cycle that the held one is accepted, so consecutive words flow
  // without a gap. A word that completes while the held one is stalled is
  // lost, and the overflow pulse reports that loss.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stb      <= 1'b0;
      o_codword  <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= 1'b0;
      if (o_stb && !i_busy) begin
        o_stb <= 1'b0;
      end
      if (complete) begin
        if (!o_stb || !i_busy) begin
          o_stb     <= 1'b1;
          o_codword <= complete_word;
        end else begin
          o_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wbu_input_assemble.sv
// tb_wbu_input_assemble
// Directed bench for wbu_input_assemble. Expected codewords are pushed into
// a scoreboard queue when the stimulus is issued. A monitor pops and compares
// on every accepted transfer. Inputs change 1 ns after the rising edge, and
// outputs are sampled on the falling edge or 1 ns after the rising edge.
module tb_wbu_input_assemble;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_stb = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        o_stb;
  logic [35:0] o_codword;
  logic        i_busy = 1'b0;
  logic        o_active;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;
  int xfer_count = 0;
  int overflow_count = 0;
  logic [35:0] exp_q[$];

  string alpha = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz@%";

  wbu_input_assemble dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_stb      (i_stb),
    .i_byte     (i_byte),
    .o_stb      (o_stb),
    .o_codword  (o_codword),
    .i_busy     (i_busy),
    .o_active   (o_active),
    .o_overflow (o_overflow)
  );

  // 100 MHz clock.
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Presents one byte for exactly one cycle starting 1 ns after the next edge.
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge i_clk);
    #1;
    i_stb  = 1'b1;
    i_byte = b;
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
      i_stb = 1'b0;
    end
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      applyIdle(1);
      n++;
    end
    applyIdle(2);
    checkOutput("scoreboard drained", 36'(exp_q.size()), 36'd0);
  endtask

  function automatic int modelIndex(input logic [7:0] b);
    for (int i = 0; i < 64; i++) begin
      if (alpha[i] == b) return i;
    end
    return -1;
  endfunction

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_overflow) overflow_count++;
      if (o_stb && !i_busy) begin
        xfer_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected transfer: got %h expected none", o_codword);
        end else begin
          checkOutput("transfer codeword", o_codword, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ovf_base;
    int xfer_base;
    int words_expected;
    int idx;
    logic [5:0] s;
    int len;
    logic [7:0] bv;

    // Reset state.
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset o_stb", 36'(o_stb), 36'd0);
    checkOutput("reset o_codword", o_codword, 36'd0);
    checkOutput("reset o_active", 36'(o_active), 36'd0);
    checkOutput("reset o_overflow", 36'(o_overflow), 36'd0);
    i_rst = 1'b0;
    applyIdle(2);

    // Full six-sextet word "A12345".
    $display("[TB] full word");
    exp_q.push_back(36'h281083105);
    applyStimulus("A");
    applyStimulus("1");
    applyStimulus("2");
    applyStimulus("3");
    applyStimulus("4");
    checkOutput("full active mid-word", 36'(o_active), 36'd1);
    applyStimulus("5");
    applyIdle(1);
    checkOutput("full o_stb at N+1", 36'(o_stb), 36'd0);
    applyIdle(1);
    checkOutput("full o_stb at N+2", 36'(o_stb), 36'd1);
    checkOutput("full codeword at N+2", o_codword, 36'h281083105);
    waitDrain(20);
    checkOutput("full active after", 36'(o_active), 36'd0);

    // Short words "z" then "a%".
    $display("[TB] short words");
    exp_q.push_back(36'hF40000000);
    exp_q.push_back(36'h93F000000);
    applyStimulus("z");
    applyStimulus("a");
    applyStimulus("%");
    waitDrain(20);

    // Two single-sextet words on consecutive cycles, then check for no gap.
    $display("[TB] back-to-back");
    exp_q.push_back(36'hF40000000);
    exp_q.push_back(36'hF00000000);
    applyStimulus("z");
    applyStimulus("y");
    applyIdle(1);
    checkOutput("b2b first o_stb", 36'(o_stb), 36'd1);
    checkOutput("b2b first codeword", o_codword, 36'hF40000000);
    applyIdle(1);
    checkOutput("b2b second o_stb", 36'(o_stb), 36'd1);
    checkOutput("b2b second codeword", o_codword, 36'hF00000000);
    waitDrain(20);

    // Abort by newline.
    $display("[TB] abort");
    exp_q.push_back(36'hF40000000);
    applyStimulus("A");
    applyStimulus("1");
    applyStimulus(8'h0A);
    applyStimulus("z");
    checkOutput("abort active before", 36'(o_active), 36'd1);
    applyIdle(1);
    checkOutput("abort active after", 36'(o_active), 36'd0);
    waitDrain(20);

    // Backpressure and overflow.
    $display("[TB] backpressure");
    ovf_base = overflow_count;
    xfer_base = xfer_count;
    i_busy = 1'b1;
    exp_q.push_back(36'hF40000000);
    applyStimulus("z");
    applyStimulus("y");
    applyIdle(5);
    checkOutput("bp held o_stb", 36'(o_stb), 36'd1);
    checkOutput("bp held codeword", o_codword, 36'hF40000000);
    checkOutput("bp overflow pulses", 36'(overflow_count - ovf_base), 36'd1);
    i_busy = 1'b0;
    waitDrain(20);
    applyIdle(3);
    checkOutput("bp transfers", 36'(xfer_count - xfer_base), 36'd1);
    checkOutput("bp o_stb after", 36'(o_stb), 36'd0);

    // Reset in the middle of a word.
    $display("[TB] reset mid-word");
    applyStimulus("A");
    applyStimulus("1");
    applyStimulus("2");
    @(posedge i_clk);
    #1;
    i_stb = 1'b0;
    i_rst = 1'b1;
    #2;
    checkOutput("midrst o_stb", 36'(o_stb), 36'd0);
    checkOutput("midrst o_codword", o_codword, 36'd0);
    checkOutput("midrst o_active", 36'(o_active), 36'd0);
    checkOutput("midrst o_overflow", 36'(o_overflow), 36'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    exp_q.push_back(36'hF40000000);
    applyStimulus("z");
    waitDrain(20);

    // Alphabet sweep. Valid bytes are padded with '0' sextets up to their
    // word length, so each produces one word with the sextet on top.
    $display("[TB] alphabet sweep");
    xfer_base = xfer_count;
    words_expected = 0;
    for (int b = 0; b < 256; b++) begin
      bv = b[7:0];
      idx = modelIndex(bv);
      applyStimulus(8'h20);
      applyStimulus(bv);
      if (idx >= 0) begin
        s = idx[5:0];
        case (s[5:4])
          2'b00:   len = 6;
          2'b01:   len = 3;
          2'b10:   len = 2;
          default: len = 1;
        endcase
        for (int k = 1; k < len; k++) applyStimulus("0");
        exp_q.push_back({s, 30'b0});
        words_expected++;
      end
      applyIdle(2);
      checkOutput("sweep active low", 36'(o_active), 36'd0);
    end
    waitDrain(50);
    checkOutput("sweep word count", 36'(xfer_count - xfer_base), 36'(words_expected));
    checkOutput("sweep model count", 36'(words_expected), 36'd64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
